// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares the Bridge data bus between the CPU MEM stage and one external master
module dbus_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CPU_HOLD  = 3
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_wen,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        ext_req,
    input  logic [31:0] ext_addr,
    input  logic        ext_wen,
    input  logic [31:0] ext_wdata,
    output logic        ext_gnt,
    output logic [31:0] ext_rdata,
    output logic        ext_rvalid,
    output logic [31:0] Bus_addr,
    output logic        Bus_wen,
    output logic [31:0] Bus_wdata,
    input  logic [31:0] Bus_rdata,
    output logic        bus_owner
);
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_EXT = 1'b1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int HW = $clog2(CPU_HOLD + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(CPU_HOLD - 1);

    logic          state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          ext_own;

    assign ext_own    = state_q == OWN_EXT;
    assign bus_owner  = state_q;
    assign Bus_addr   = ext_own ? ext_addr : cpu_addr;
    assign Bus_wdata  = ext_own ? ext_wdata : cpu_wdata;
    assign Bus_wen    = cpu_rst & (ext_own ? ext_req & ext_wen : cpu_req & cpu_wen);
    assign ext_gnt    = cpu_rst & ext_own & ext_req;
    assign ext_rvalid = ext_gnt & ~ext_wen;
    assign cpu_stall  = cpu_rst & ext_own & cpu_req;
    assign cpu_rdata  = Bus_rdata;
    assign ext_rdata  = Bus_rdata;

    // Ownership decision: CPU yields after CPU_HOLD contended cycles, external yields after MAX_BURST beats
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        hold_d  = hold_q;
        if (state_q == OWN_CPU) begin
            if (!ext_req) begin
                hold_d = '0;
            end else if (!cpu_req || hold_q == HOLD_LAST) begin
                state_d = OWN_EXT;
                burst_d = '0;
                hold_d  = '0;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end else begin
            if (!ext_req) begin
                state_d = OWN_CPU;
                burst_d = '0;
            end else if (burst_q == BURST_LAST) begin
                state_d = cpu_req ? OWN_CPU : OWN_EXT;
                burst_d = cpu_req ? '0 : burst_q;
            end else begin
                burst_d = burst_q + 1'b1;
            end
        end
    end

    // State and counters, cleared by the active-low synchronous reset
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) begin
            state_q <= OWN_CPU;
            burst_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            hold_q  <= hold_d;
        end
    end
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: randomized and directed checks of dbus_arbiter against a behavioural model
module tb_dbus_arbiter;
    localparam int MAX_BURST = 4;
    localparam int CPU_HOLD  = 3;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst, cpu_req, cpu_wen, ext_req, ext_wen;
    logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata, bus_rd;
    logic [31:0] cpu_rdata, ext_rdata, Bus_addr, Bus_wdata;
    logic        cpu_stall, ext_gnt, ext_rvalid, Bus_wen, bus_owner;

    int n_checks = 0;
    int n_pass   = 0;

    int m_own   = 0;
    int m_hold  = 0;
    int m_beats = 0;
    logic [100:0] exp_v;
    logic         e_rv;

    dbus_arbiter #(.MAX_BURST(MAX_BURST), .CPU_HOLD(CPU_HOLD)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_wen(cpu_wen), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_addr(ext_addr), .ext_wen(ext_wen), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
        .Bus_addr(Bus_addr), .Bus_wen(Bus_wen), .Bus_wdata(Bus_wdata), .Bus_rdata(bus_rd),
        .bus_owner(bus_owner)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Arbitration rules in terms of "cycles served" and "beats granted"
    task automatic model_edge();
        if (!cpu_rst) begin
            m_own = 0; m_hold = 0; m_beats = 0;
        end else if (m_own == 0) begin
            if (ext_req && !cpu_req) begin
                m_own = 1; m_beats = 0; m_hold = 0;
            end else if (ext_req) begin
                m_hold++;
                if (m_hold == CPU_HOLD) begin m_own = 1; m_hold = 0; m_beats = 0; end
            end else m_hold = 0;
        end else begin
            if (!ext_req) begin
                m_own = 0; m_beats = 0;
            end else begin
                m_beats++;
                if (m_beats >= MAX_BURST && cpu_req) begin m_own = 0; m_beats = 0; end
            end
        end
    endtask

    task automatic settle();
        logic on, own, wen, gnt, stall;
        @(negedge cpu_clk);
        on    = cpu_rst;
        own   = (m_own != 0);
        wen   = on & (own ? ext_req & ext_wen : cpu_req & cpu_wen);
        gnt   = on & own & ext_req;
        e_rv  = gnt & ~ext_wen;
        stall = on & own & cpu_req;
        exp_v = {own, wen, gnt, e_rv, stall, own ? ext_addr : cpu_addr,
                 own ? ext_wdata : cpu_wdata, (!own || e_rv) ? bus_rd : 32'h0};
    endtask

    function automatic logic [100:0] obs_vec();
        return {bus_owner, Bus_wen, ext_gnt, ext_rvalid, cpu_stall, Bus_addr, Bus_wdata,
                (m_own == 0) ? cpu_rdata : (e_rv ? ext_rdata : 32'h0)};
    endfunction

    task automatic adv();
        @(posedge cpu_clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; ext_req = 0; cpu_wen = 0; ext_wen = 0; cpu_rst = 1;
    endtask

    task automatic test_reset();
        cpu_rst = 0; ext_req = 1; cpu_req = 1; cpu_wen = 1; ext_wen = 1;
        cpu_addr = 32'h40; cpu_wdata = 32'h11; ext_addr = 32'h80; ext_wdata = 32'h22;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_checks++;
            if (obs_vec() !== exp_v) $display("FAIL reset_model cyc %0d: got %h want %h", i, obs_vec(), exp_v);
            else n_pass++;
            n_checks++;
            if ({Bus_wen, ext_gnt, cpu_stall} !== 3'b000) $display("FAIL reset_gate cyc %0d: got %b want 000", i, {Bus_wen, ext_gnt, cpu_stall});
            else n_pass++;
            adv();
        end
        cpu_rst = 1;
        settle();
        n_checks++;
        if ({bus_owner, Bus_addr} !== {1'b0, 32'h40}) $display("FAIL reset_release: got %h want %h", {bus_owner, Bus_addr}, {1'b0, 32'h40});
        else n_pass++;
        adv();
        idle();
        settle();
        adv();
    endtask

    task automatic test_cpu_only();
        idle();
        cpu_req = 1; cpu_wen = 1; cpu_addr = 32'h8010; cpu_wdata = 32'hDEADBEEF; bus_rd = 32'h0;
        settle();
        n_checks++;
        if ({Bus_wen, Bus_addr, Bus_wdata, cpu_stall} !== {1'b1, 32'h8010, 32'hDEADBEEF, 1'b0})
            $display("FAIL cpu_store: got %h want %h", {Bus_wen, Bus_addr, Bus_wdata, cpu_stall}, {1'b1, 32'h8010, 32'hDEADBEEF, 1'b0});
        else n_pass++;
        adv();
        cpu_wen = 0; bus_rd = 32'h12345678;
        settle();
        n_checks++;
        if ({cpu_rdata, cpu_stall, Bus_wen} !== {32'h12345678, 2'b00})
            $display("FAIL cpu_load: got %h want %h", {cpu_rdata, cpu_stall, Bus_wen}, {32'h12345678, 2'b00});
        else n_pass++;
        adv();
        for (int i = 0; i < 10; i++) begin
            cpu_req = 1'($urandom); cpu_wen = 1'($urandom);
            cpu_addr = $urandom; cpu_wdata = $urandom; bus_rd = $urandom;
            settle();
            n_checks++;
            if (obs_vec() !== exp_v) $display("FAIL cpu_only cyc %0d: got %h want %h", i, obs_vec(), exp_v);
            else n_pass++;
            adv();
        end
        idle();
    endtask

    task automatic test_ext_only();
        int beats = 0;
        idle();
        for (int i = 0; i < 9; i++) begin
            ext_req = (i < 7); ext_wen = 0;
            ext_addr = 32'h100 + 32'(4 * beats); bus_rd = $urandom;
            settle();
            n_checks++;
            if (obs_vec() !== exp_v) $display("FAIL ext_only cyc %0d: got %h want %h", i, obs_vec(), exp_v);
            else n_pass++;
            if (ext_gnt) beats++;
            if (i == 8) begin
                n_checks++;
                if (bus_owner !== 1'b0) $display("FAIL ext_return: got %b want 0", bus_owner);
                else n_pass++;
            end
            adv();
        end
        n_checks++;
        if (beats != 6) $display("FAIL ext_beats: got %0d want 6", beats);
        else n_pass++;
        idle();
    endtask

    task automatic test_burst_limit();
        int beats = 0;
        int stalls = 0;
        idle();
        ext_req = 1; cpu_addr = 32'h2000; cpu_wdata = 32'hA5A5A5A5; cpu_wen = 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) cpu_req = 1;
            ext_addr = $urandom; ext_wdata = $urandom; ext_wen = 1'($urandom); bus_rd = $urandom;
            settle();
            n_checks++;
            if (obs_vec() !== exp_v) $display("FAIL burst cyc %0d: got %h want %h", i, obs_vec(), exp_v);
            else n_pass++;
            if (ext_gnt) beats++;
            if (cpu_stall) stalls++;
            if (i == 5) begin
                n_checks++;
                if ({bus_owner, cpu_stall, Bus_wen, Bus_addr} !== {3'b001, 32'h2000})
                    $display("FAIL burst_cpu_done: got %h want %h", {bus_owner, cpu_stall, Bus_wen, Bus_addr}, {3'b001, 32'h2000});
                else n_pass++;
            end
            adv();
        end
        n_checks++;
        if (beats != MAX_BURST || stalls != 3) $display("FAIL burst_count: got beats %0d stalls %0d want 4 3", beats, stalls);
        else n_pass++;
        idle();
        settle();
        adv();
    endtask

    task automatic test_forced_handoff();
        idle();
        cpu_req = 1; ext_req = 1; cpu_wen = 1;
        for (int i = 0; i < 21; i++) begin
            ext_wen = 1'($urandom); cpu_addr = $urandom; ext_addr = $urandom;
            cpu_wdata = $urandom; ext_wdata = $urandom; bus_rd = $urandom;
            settle();
            n_checks++;
            if (obs_vec() !== exp_v) $display("FAIL handoff cyc %0d: got %h want %h", i, obs_vec(), exp_v);
            else n_pass++;
            n_checks++;
            if (bus_owner !== ((i % 7) >= CPU_HOLD)) $display("FAIL handoff_pattern cyc %0d: got %b want %b", i, bus_owner, (i % 7) >= CPU_HOLD);
            else n_pass++;
            adv();
        end
        idle();
        settle();
        adv();
    endtask

    task automatic test_reset_mid_burst();
        int beats = 0;
        idle();
        ext_req = 1; ext_wen = 0;
        for (int i = 0; i < 14; i++) begin
            cpu_rst = (i != 2);
            cpu_req = (i >= 4);
            ext_addr = $urandom; bus_rd = $urandom;
            settle();
            n_checks++;
            if (obs_vec() !== exp_v) $display("FAIL rst_burst cyc %0d: got %h want %h", i, obs_vec(), exp_v);
            else n_pass++;
            if (i == 2 || i == 3) begin
                n_checks++;
                if ({ext_gnt, (i == 3) & bus_owner} !== 2'b00) $display("FAIL rst_burst_gate cyc %0d: got %b want 00", i, {ext_gnt, bus_owner});
                else n_pass++;
            end
            if (i >= 4 && i < 10 && ext_gnt) beats++;
            adv();
        end
        n_checks++;
        if (beats != MAX_BURST) $display("FAIL rst_burst_full: got %0d want %0d", beats, MAX_BURST);
        else n_pass++;
        idle();
        settle();
        adv();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cpu_rst = ($urandom % 40) != 0;
            cpu_req = ($urandom % 3) != 0; ext_req = ($urandom % 3) != 0;
            cpu_wen = 1'($urandom); ext_wen = 1'($urandom);
            cpu_addr = $urandom; ext_addr = $urandom; cpu_wdata = $urandom; ext_wdata = $urandom;
            bus_rd = $urandom;
            settle();
            n_checks++;
            if (obs_vec() !== exp_v) $display("FAIL random cyc %0d: got %h want %h", i, obs_vec(), exp_v);
            else n_pass++;
            adv();
        end
        idle();
    endtask

    initial begin
        cpu_rst = 0; cpu_req = 0; cpu_wen = 0; ext_req = 0; ext_wen = 0;
        cpu_addr = 0; cpu_wdata = 0; ext_addr = 0; ext_wdata = 0; bus_rd = 0;
        adv();
        test_reset();
        test_cpu_only();
        test_ext_only();
        test_burst_limit();
        test_forced_handoff();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the single Bridge data bus (Bus_addr/Bus_wen/Bus_wdata/Bus_rdata) between the CPU MEM stage and one external master (debug loader / DMA).
- The CPU keeps zero-latency access when there is no contention. The external master gets bounded bursts, and the CPU is stalled while it waits.
- Sits between the pipeline's MEM-stage bus outputs and the Bridge. cpu_stall feeds the pipeline's hazard/stall logic.

Parameters:
- MAX_BURST, 4: maximum consecutive external beats before yielding to a waiting CPU (≥1).
- CPU_HOLD, 3: maximum consecutive contended cycles the CPU keeps the bus before a forced handoff (≥1).

Ports:
- cpu_clk  in  1  clock; all state updates on rising edge.
- cpu_rst  in  1  synchronous reset, active-low.
- cpu_req  in  1  MEM stage performs a load/store this cycle.
- cpu_addr  in  32  CPU byte address.
- cpu_wen  in  1  CPU store.
- cpu_wdata  in  32  CPU store data.
- cpu_rdata  out  32  load data to MEM/WB.
- cpu_stall  out  1  freezes the pipeline (PC..MEM_WB hold).
- ext_req  in  1  external master requests a beat.
- ext_addr  in  32  external address.
- ext_wen  in  1  external write.
- ext_wdata  in  32  external write data.
- ext_gnt  out  1  external beat accepted this cycle.
- ext_rdata  out  32  external read data.
- ext_rvalid  out  1  ext_rdata valid this cycle.
- Bus_addr  out  32  to Bridge.
- Bus_wen  out  1  to Bridge.
- Bus_wdata  out  32  to Bridge.
- Bus_rdata  in  32  from Bridge; combinational, same-cycle read.
- bus_owner  out  1  0 = CPU, 1 = external (debug/trace).

Behaviour:
- Reset: cpu_rst sampled low at an edge sets state = OWN_CPU and clears burst_cnt and hold_cnt. This holds mid-burst too: the next cycle is OWN_CPU.
- While cpu_rst is low: Bus_wen = 0, ext_gnt = 0, ext_rvalid = 0, cpu_stall = 0.
- States:
  - OWN_CPU: bus_owner = 0.
  - OWN_EXT: bus_owner = 1.
  - No dead cycle at handoff; the owner switches exactly at the edge.
- Bus mux in OWN_CPU:
  - Bus_addr = cpu_addr, Bus_wdata = cpu_wdata, Bus_wen = cpu_req & cpu_wen.
  - cpu_rdata = Bus_rdata.
  - ext_gnt = 0, ext_rvalid = 0.
- Bus mux in OWN_EXT:
  - Bus_addr = ext_addr, Bus_wdata = ext_wdata, Bus_wen = ext_req & ext_wen.
  - ext_gnt = ext_req; ext_rvalid = ext_req & ~ext_wen; ext_rdata = Bus_rdata.
  - cpu_rdata is don't-care.
- cpu_stall = cpu_req & (state == OWN_EXT), combinational.
  - A stalled CPU holds cpu_req/addr/wdata stable; the access completes in the first OWN_CPU cycle.
- OWN_CPU transitions:
  - ext_req & ~cpu_req → OWN_EXT, burst_cnt ← 0.
  - ext_req & cpu_req: hold_cnt increments. When hold_cnt == CPU_HOLD-1 at this edge → OWN_EXT, hold_cnt ← 0. The CPU access in that cycle still completes.
  - ~ext_req → stay, hold_cnt ← 0.
- OWN_EXT transitions:
  - ext_req: burst_cnt increments per granted beat.
  - ~ext_req → OWN_CPU next edge, burst_cnt ← 0.
  - burst_cnt == MAX_BURST-1 with a beat this cycle, and cpu_req high → OWN_CPU, burst_cnt ← 0.
  - If cpu_req is low at the limit, stay. burst_cnt saturates at MAX_BURST-1 and the check repeats each beat.
- Fairness: after a forced return, hold_cnt restarts at 0. Under continuous dual contention, ownership alternates in the pattern CPU_HOLD cycles CPU, then MAX_BURST beats external.
- Counter widths: $clog2(MAX_BURST+1) and $clog2(CPU_HOLD+1); no wrap beyond the limits.
- An ext_req that drops while in OWN_CPU is not latched; nothing is pending afterwards.

Test Plan:
- Reset/idle: cpu_rst = 0 for 2 cycles with ext_req = 1, cpu_req = 1, cpu_wen = 1 → Bus_wen = 0, ext_gnt = 0, cpu_stall = 0. After release: bus_owner = 0 and Bus_addr = cpu_addr.
- CPU only: store to 0x8010 with data 0xDEADBEEF → Bus_wen = 1 the same cycle with that addr/data, cpu_stall never asserts. Load with Bus_rdata = 0x12345678 → cpu_rdata = 0x12345678 the same cycle.
- External only: ext_req held for 6 reads at 0x100..0x114, cpu_req = 0 → one OWN_CPU cycle, then ext_gnt = 1 for 6 consecutive cycles, ext_rvalid = 1 with ext_rdata = Bus_rdata, then return to OWN_CPU the edge after ext_req drops.
- Burst limit (MAX_BURST = 4): ext_req continuous, cpu_req rises during beat 2 → exactly 4 ext_gnt beats, with cpu_stall = 1 during beats 2–4. The CPU owns the bus on the next cycle, its access completes, and cpu_stall = 0.
- Forced handoff (CPU_HOLD = 3): cpu_req and ext_req both continuous from OWN_CPU → 3 CPU cycles, then 4 ext beats, repeating (3/4 alternation over 21 cycles). No Bus_wen from the non-owner ever.
- Reset mid-burst: cpu_rst = 0 during ext beat 2 → the next cycle is OWN_CPU with ext_gnt = 0. A following fresh ext_req gets a full 4-beat burst, confirming burst_cnt was cleared.
